// File: rtl/ram_tp_bytemask_init_if.sv
// ---------------------------------------------------------------------------
// ram_tp_bytemask_init_if
// Bundles the user-side request and response signals of the two-port
// byte-masked RAM so a bench or client block can hand one handle around.
//
//   cen        chip enable for both ports
//   wen        write request
//   bwen       per-lane write enables (NB lanes)
//   waddr      write address
//   wdata      write data
//   ren        read request
//   raddr      read address
//   rdata      read result, meaningful while rvalid is high
//   rvalid     one-cycle strobe per accepted read
//   init_busy  high while the post-reset clear sweep is running
//
// master modport: the client that issues requests.
// slave modport : the RAM itself.
// ---------------------------------------------------------------------------
interface ram_tp_bytemask_init_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int DEPTH      = 16
);
   localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NB         = DATA_WIDTH / BYTE_WIDTH;

   logic                  cen;
   logic                  wen;
   logic [NB-1:0]         bwen;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ren;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  init_busy;

   modport master (
      output cen, wen, bwen, waddr, wdata, ren, raddr,
      input  rdata, rvalid, init_busy
   );

   modport slave (
      input  cen, wen, bwen, waddr, wdata, ren, raddr,
      output rdata, rvalid, init_busy
   );
endinterface

// File: rtl/ram_tp_bytemask_init.sv
// ---------------------------------------------------------------------------
// ram_tp_bytemask_init
// Two-port (one write, one read) synchronous RAM with byte-lane write masks,
// a post-reset clear sweep, a selectable 1- or 2-cycle read latency with an
// rvalid strobe, and a selectable same-address read/write collision policy.
//
// Ports
//   clock   sole clock, rising edge
//   reset   asynchronous, active-high
//   bus     slave side of ram_tp_bytemask_init_if (requests in, rdata/rvalid/
//           init_busy out)
//
// Parameters
//   DATA_WIDTH     word width, a multiple of BYTE_WIDTH
//   BYTE_WIDTH     bits per write-enable lane
//   DEPTH          number of words, need not be a power of two
//   RD_LATENCY     1 = registered read, 2 = one extra output stage
//   INIT_ON_RESET  1 = clear every word after reset
//   INIT_VALUE     value written by the clear sweep
//   COLLISION_MODE 0 = same-address read returns the old word,
//                  1 = written lanes are forwarded to the read
// ---------------------------------------------------------------------------
module ram_tp_bytemask_init #(
   parameter int                   DATA_WIDTH     = 32,
   parameter int                   BYTE_WIDTH     = 8,
   parameter int                   DEPTH          = 16,
   parameter int                   RD_LATENCY     = 1,
   parameter bit                   INIT_ON_RESET  = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
   parameter bit                   COLLISION_MODE = 1'b0
) (
   input logic                   clock,
   input logic                   reset,
   ram_tp_bytemask_init_if.slave bus
);

   localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NB         = DATA_WIDTH / BYTE_WIDTH;

   // One extra bit so DEPTH itself is representable for the range checks.
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [NB-1:0]         lane_we;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_acc;
   logic                  waddr_ok;
   logic                  raddr_ok;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  rvalid_q;

   assign waddr_ok = ({1'b0, bus.waddr} < DEPTH_W);
   assign raddr_ok = ({1'b0, bus.raddr} < DEPTH_W);

   // State and sweep-counter register. Reset drops straight back into the
   // clear sweep from address 0 (or to READY when no sweep is wanted).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= INIT_ON_RESET ? ST_INIT : ST_READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic and write-port steering. During the sweep the write
   // port is owned by the counter and every user request is ignored; once
   // READY, a write only lands when the address is inside the array.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lane_we = '0;
      wr_addr = bus.waddr;
      wr_data = bus.wdata;
      rd_acc  = 1'b0;
      case (state_q)
         ST_INIT: begin
            lane_we = '1;
            wr_addr = cnt_q;
            wr_data = INIT_VALUE;
            cnt_d   = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (bus.cen && bus.wen && waddr_ok) begin
               lane_we = bus.bwen;
            end
            rd_acc = bus.cen && bus.ren;
         end
         default: begin
            state_d = ST_READY;
         end
      endcase
   end

   // The storage array has no reset; only the enabled lanes are touched.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NB; i++) begin
         if (lane_we[i]) begin
            mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // Read word as seen by an accepted read. The array read happens before
   // the edge, so it naturally returns the pre-write word; in write-through
   // mode the lanes being written to the same address are patched in.
   // Out-of-range addresses read as zero.
   always_comb begin
      rd_word = '0;
      if (raddr_ok) begin
         rd_word = mem[bus.raddr];
         if (COLLISION_MODE && (wr_addr == bus.raddr)) begin
            for (int i = 0; i < NB; i++) begin
               if (lane_we[i]) begin
                  rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
               end
            end
         end
      end
   end

   // Output pipeline. Data registers only load alongside a valid so rdata
   // holds its last result between strobes; the pipeline runs regardless of
   // cen so a read in flight always completes.
   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] s1_data;
         logic                  s1_valid;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               s1_data  <= '0;
               s1_valid <= 1'b0;
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               s1_valid <= rd_acc;
               if (rd_acc) begin
                  s1_data <= rd_word;
               end
               rvalid_q <= s1_valid;
               if (s1_valid) begin
                  rdata_q <= s1_data;
               end
            end
         end
      end else begin : g_lat1
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rvalid_q <= rd_acc;
               if (rd_acc) begin
                  rdata_q <= rd_word;
               end
            end
         end
      end
   endgenerate

   assign bus.rdata     = rdata_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.init_busy = (state_q == ST_INIT);

endmodule
